// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the stream FIFO: pointer sizing and the even-parity function.
package stream_fifo_pkg;

    // Parity inputs are zero-extended to this width; extension never changes parity.
    localparam int PARITY_MAX_W = 1024;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Flop-array storage: one synchronous write port, one combinational read port, no reset.
module stream_fifo_mem #(
    parameter int  WIDTH = 33,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_parity_fifo.sv
// Valid/ready elastic buffer with occupancy count and optional per-beat even-parity check.
module stream_parity_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter bit ENABLE_PARITY = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       parity_err
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int MEM_W = WIDTH + (ENABLE_PARITY ? 1 : 0);

    typedef struct packed {
        logic             wrap;
        logic [PTR_W-2:0] idx;
    } ptr_t;

    ptr_t             wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [MEM_W-1:0] wdata, rdata;

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr.idx == rd_ptr.idx) && (wr_ptr.wrap != rd_ptr.wrap);
    assign ready_out = !full;
    assign valid_out = !empty;
    assign push      = valid_in && ready_out;
    assign pop       = valid_out && ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_t'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= ptr_t'(rd_ptr + 1'b1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    stream_fifo_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr.idx),
        .wdata (wdata),
        .raddr (rd_ptr.idx),
        .rdata (rdata)
    );

    assign data_out = rdata[WIDTH-1:0];

    generate
        if (ENABLE_PARITY) begin : g_par
            logic par_mismatch;

            // Stored bit rides above the payload in the same entry.
            assign wdata        = {even_parity(PARITY_MAX_W'(data_in)), data_in};
            assign par_mismatch = even_parity(PARITY_MAX_W'(data_out)) != rdata[WIDTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) parity_err <= 1'b0;
                else     parity_err <= pop && par_mismatch;
            end
        end else begin : g_nopar
            assign wdata      = data_in;
            assign parity_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_stream_parity_fifo.sv
// Randomised and directed checks of stream_parity_fifo against a queue-based reference model.
module tb_stream_parity_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ready_in;
    logic [4:0]       count;
    logic             parity_err;

    always #5 clk = ~clk;

    stream_parity_fifo #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .ENABLE_PARITY (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .count      (count),
        .parity_err (parity_err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mq[$];
    bit          mp[$];
    bit          m_err;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: a queue of beats plus the parity recorded when each was accepted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mp.delete();
            m_err = 1'b0;
        end else begin
            bit pu, po;
            pu    = valid_in && (mq.size() < DEPTH);
            po    = ready_in && (mq.size() > 0);
            m_err = po && ((^mq[0]) != mp[0]);
            if (po) begin
                void'(mq.pop_front());
                void'(mp.pop_front());
            end
            if (pu) begin
                mq.push_back(data_in);
                mp.push_back(^data_in);
            end
        end
    end

    always @(negedge clk) begin
        check("valid_out", 32'(valid_out), 32'(mq.size() > 0));
        check("ready_out", 32'(ready_out), 32'(mq.size() < DEPTH));
        check("count", 32'(count), 32'(mq.size()));
        check("parity_err", 32'(parity_err), 32'(m_err));
        if (mq.size() > 0) check("data_out", data_out, mq[0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        rst = 1'b0;
        step();

        // Fill with 1..16 while stalled, then drain in order.
        for (int i = 1; i <= 16; i++) begin
            data_in  = 32'(i);
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ready", 32'(ready_out), 32'd0);
        ready_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("pop_order", data_out, 32'(i));
            @(negedge clk);
        end
        ready_in = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(valid_out), 32'd0);

        // Streaming: one in, one out per cycle, no bubbles.
        valid_in = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data_in = $urandom;
            step();
            check("stream_count", 32'(count), 32'd1);
            check("stream_valid", 32'(valid_out), 32'd1);
        end
        valid_in = 1'b0;
        step();
        check("stream_end", 32'(count), 32'd0);

        // Full FIFO refuses a write even with a pop in the same cycle.
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = $urandom;
            step();
        end
        check("full_16", 32'(count), 32'd16);
        data_in  = 32'h5555AAAA;
        ready_in = 1'b1;
        step();
        check("full_15", 32'(count), 32'd15);
        ready_in = 1'b0;
        step();
        check("full_16b", 32'(count), 32'd16);
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (16) step();
        check("full_drain", 32'(count), 32'd0);

        // Burst passes that carry the pointers across the wrap point.
        for (int p = 0; p < 3; p++) begin
            ready_in = 1'b0;
            valid_in = 1'b1;
            for (int i = 0; i < 10; i++) begin
                data_in = $urandom;
                step();
            end
            valid_in = 1'b0;
            check("wrap_count10", 32'(count), 32'd10);
            ready_in = 1'b1;
            repeat (10) step();
            check("wrap_count0", 32'(count), 32'd0);
            check("wrap_empty", 32'(valid_out), 32'd0);
            check("wrap_ready", 32'(ready_out), 32'd1);
        end

        // Random traffic, first biased to fill then biased to drain.
        for (int i = 0; i < 500; i++) begin
            data_in  = $urandom;
            valid_in = (i < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            ready_in = (i < 250) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (20) step();
        ready_in = 1'b0;

        // Parity: corrupt payload bit 0 of the second stored beat.
        rst = 1'b1;
        step();
        rst      = 1'b0;
        data_in  = 32'h00000003;
        valid_in = 1'b1;
        step();
        data_in = 32'hA5A5A5A5;
        step();
        valid_in = 1'b0;
        dut.u_mem.mem[1][0] = ~dut.u_mem.mem[1][0];
        mq[1] = mq[1] ^ 32'h1;
        check("par_idle", 32'(parity_err), 32'd0);
        ready_in = 1'b1;
        step();
        check("par_clean", 32'(parity_err), 32'd0);
        check("par_data", data_out, 32'hA5A5A5A4);
        step();
        check("par_err", 32'(parity_err), 32'd1);
        ready_in = 1'b0;
        step();
        check("par_pulse", 32'(parity_err), 32'd0);

        // Reset mid-burst clears state immediately, ignoring concurrent writes.
        valid_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = $urandom;
            step();
        end
        check("mid_count7", 32'(count), 32'd7);
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(valid_out), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        check("mid_ready", 32'(ready_out), 32'd1);
        step();
        rst     = 1'b0;
        data_in = 32'hDEADBEEF;
        step();
        valid_in = 1'b0;
        check("post_rst_data", data_out, 32'hDEADBEEF);
        check("post_rst_count", 32'(count), 32'd1);
        ready_in = 1'b1;
        step();
        check("post_rst_drain", 32'(count), 32'd0);
        ready_in = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
